// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised sequence detector.
// Holds the hunt/forward state encoding, default parameters and the frame-count step.
package seq_det_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    FORWARD = 1'b1
  } seqState_e;

  localparam int DEF_PAT_W    = 4;
  localparam int DEF_LEN_W    = 4;
  localparam int DEF_CNT_W    = 4;
  localparam bit DEF_SATURATE = 1'b0;

  // Next frame count; counters up to 32 bits wide.
  function automatic logic [31:0] frameCountNext(input logic [31:0] cnt,
                                                 input logic [31:0] maxVal,
                                                 input bit          saturate);
    if (cnt == maxVal) return saturate ? maxVal : 32'd0;
    return cnt + 32'd1;
  endfunction

endpackage

// File: rtl/pattern_shift_matcher.sv
// Serial history register with fill counter and live compare against the start pattern.
// The match output looks one bit ahead: it reports whether shifting serIn in now completes the pattern.
module pattern_shift_matcher #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shiftEn,
  input  logic             clear,
  input  logic             serIn,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  history;
  logic [PAT_W-1:0]  histNext;
  logic [FILL_W-1:0] fill;

  assign histNext = {history[PAT_W-2:0], serIn};
  assign match    = (fill >= FILL_ARM) && (histNext == pattern);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history <= '0;
      fill    <= '0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
    end else if (shiftEn) begin
      history <= histNext;
      if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
    end
  end

endmodule

// File: rtl/param_sequence_detector.sv
// Hunts for a start pattern on serIn, then forwards payloadLen enabled bits and counts frames.
// serOutValid is a one-cycle strobe qualifying serOut; there is no ready, every strobe must be taken.
module param_sequence_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W    = DEF_PAT_W,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter bit SATURATE = DEF_SATURATE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  logic             serIn,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] payloadLen,
  output logic             serOut,
  output logic             serOutValid,
  output logic [CNT_W-1:0] countOut,
  output logic             frameDone,
  output logic             busy,
  output logic             dbgState
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seqState_e        state, stateNext;
  logic [LEN_W-1:0] remaining, remNext;
  logic             serOutNext, validNext, doneNext;
  logic [CNT_W-1:0] countNext, countInc;
  logic             shiftEn, histClear, match;

  pattern_shift_matcher #(.PAT_W(PAT_W)) uMatcher (
    .clk     (clk),
    .rst     (rst),
    .shiftEn (shiftEn),
    .clear   (histClear),
    .serIn   (serIn),
    .pattern (pattern),
    .match   (match)
  );

  assign countInc = CNT_W'(frameCountNext(32'(countOut), 32'(CNT_MAX), SATURATE));
  assign busy     = (state == FORWARD);
  assign dbgState = state;

  always_comb begin
    stateNext  = state;
    remNext    = remaining;
    serOutNext = serOut;
    validNext  = 1'b0;
    doneNext   = 1'b0;
    countNext  = countOut;
    shiftEn    = 1'b0;
    histClear  = 1'b0;
    if (clkEn) begin
      case (state)
        HUNT: begin
          shiftEn = 1'b1;
          if (match) begin
            histClear = 1'b1;
            if (payloadLen != '0) begin
              stateNext = FORWARD;
              remNext   = payloadLen;
            end else begin
              doneNext  = 1'b1;
              countNext = countInc;
            end
          end
        end
        FORWARD: begin
          // Keep history empty so no pattern can straddle payload and hunt bits.
          histClear  = 1'b1;
          serOutNext = serIn;
          validNext  = 1'b1;
          remNext    = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            stateNext = HUNT;
            doneNext  = 1'b1;
            countNext = countInc;
          end
        end
        default: stateNext = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      remaining   <= '0;
      serOut      <= 1'b0;
      serOutValid <= 1'b0;
      frameDone   <= 1'b0;
      countOut    <= '0;
    end else begin
      state       <= stateNext;
      remaining   <= remNext;
      serOut      <= serOutNext;
      serOutValid <= validNext;
      frameDone   <= doneNext;
      countOut    <= countNext;
    end
  end

endmodule

// File: tb/tb_param_sequence_detector.sv
// Directed bench for param_sequence_detector: a wrapping and a saturating instance share stimulus.
// clkEn strobes every other clk; each bit is followed by an idle clk to check pulses clear.
module tb_param_sequence_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       clkEn;
  logic       serIn;
  logic [3:0] pattern;
  logic [3:0] payloadLen;

  logic       serOutW, serOutValidW, frameDoneW, busyW, dbgW;
  logic [3:0] countW;
  logic       serOutS, serOutValidS, frameDoneS, busyS, dbgS;
  logic [3:0] countS;

  int total = 0;
  int bad   = 0;
  int expW  = 0;
  int expS  = 0;
  logic [0:0] expQ[$];

  logic vldE, outE, doneE, busyE, vldI, doneI;

  param_sequence_detector #(.PAT_W(4), .LEN_W(4), .CNT_W(4), .SATURATE(1'b0)) dutWrap (
    .clk(clk), .rst(rst), .clkEn(clkEn), .serIn(serIn), .pattern(pattern),
    .payloadLen(payloadLen), .serOut(serOutW), .serOutValid(serOutValidW),
    .countOut(countW), .frameDone(frameDoneW), .busy(busyW), .dbgState(dbgW)
  );

  param_sequence_detector #(.PAT_W(4), .LEN_W(4), .CNT_W(4), .SATURATE(1'b1)) dutSat (
    .clk(clk), .rst(rst), .clkEn(clkEn), .serIn(serIn), .pattern(pattern),
    .payloadLen(payloadLen), .serOut(serOutS), .serOutValid(serOutValidS),
    .countOut(countS), .frameDone(frameDoneS), .busy(busyS), .dbgState(dbgS)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One enabled edge carrying bit b, then one idle edge with clkEn low.
  task automatic sendBit(input logic b);
    @(negedge clk);
    serIn = b;
    clkEn = 1'b1;
    @(posedge clk);
    #1;
    vldE  = serOutValidW;
    outE  = serOutW;
    doneE = frameDoneW;
    busyE = busyW;
    checkVal("wrapSatAgree", {serOutValidS, frameDoneS, busyS}, {vldE, doneE, busyE});
    if (vldE) begin
      if (expQ.size() > 0) checkVal("payloadBit", outE, expQ.pop_front());
      else checkVal("unexpValid", vldE, 1'b0);
    end
    @(negedge clk);
    clkEn = 1'b0;
    serIn = ~b;
    @(posedge clk);
    #1;
    vldI  = serOutValidW;
    doneI = frameDoneW;
    checkVal("pulseClr", {vldI, doneI}, 2'b00);
    checkVal("serOutHold", serOutW, outE);
  endtask

  task automatic sendBits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) sendBit(bits[i]);
  endtask

  task automatic bumpCount(input string tag);
    expW = (expW + 1) % 16;
    expS = (expS < 15) ? expS + 1 : 15;
    checkVal({tag, "_cntW"}, countW, expW);
    checkVal({tag, "_cntS"}, countS, expS);
  endtask

  initial begin
    logic [8:0] hs;
    rst        = 1'b1;
    clkEn      = 1'b0;
    serIn      = 1'b0;
    pattern    = 4'b1011;
    payloadLen = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    checkVal("rstOut", {serOutW, serOutValidW, frameDoneW, busyW, dbgW}, 5'b0);
    checkVal("rstCnt", {countW, countS}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // 1: basic frame, pattern 1011 then payload 1,0,1
    sendBits(16'b101, 3);
    checkVal("t1preMatch", busyE, 1'b0);
    sendBit(1'b1);
    checkVal("t1match", {vldE, doneE, busyE}, 3'b001);
    expQ.push_back(1'b1); expQ.push_back(1'b0); expQ.push_back(1'b1);
    sendBit(1'b1); checkVal("t1p1", {vldE, doneE, busyE}, 3'b101);
    sendBit(1'b0); checkVal("t1p2", {vldE, doneE, busyE}, 3'b101);
    sendBit(1'b1); checkVal("t1p3", {vldE, doneE, busyE}, 3'b110);
    bumpCount("t1");
    checkVal("t1sbEmpty", expQ.size(), 0);

    // 2: pattern inside payload is ignored, then overlap hunt after fresh bits
    payloadLen = 4'd4;
    sendBits(16'b1011, 4);
    checkVal("t2match", busyE, 1'b1);
    expQ.push_back(1'b1); expQ.push_back(1'b0); expQ.push_back(1'b1); expQ.push_back(1'b1);
    sendBits(16'b101, 3);
    checkVal("t2mid", {vldE, doneE, busyE}, 3'b101);
    sendBit(1'b1);
    checkVal("t2end", {vldE, doneE, busyE}, 3'b110);
    bumpCount("t2");
    payloadLen = 4'd2;
    hs = 9'b011_101011;
    for (int i = 8; i >= 0; i--) begin
      sendBit(hs[i]);
      checkVal("t2hunt", {doneE, busyE}, {1'b0, (i == 0)});
    end
    payloadLen = 4'd7;
    expQ.push_back(1'b0); expQ.push_back(1'b1);
    sendBit(1'b0); checkVal("t2lenHeld1", {vldE, doneE, busyE}, 3'b101);
    sendBit(1'b1); checkVal("t2lenHeld2", {vldE, doneE, busyE}, 3'b110);
    bumpCount("t2b");

    // 3: zero-length frame
    payloadLen = 4'd0;
    sendBits(16'b1011, 4);
    checkVal("t3zero", {vldE, doneE, busyE}, 3'b010);
    bumpCount("t3");
    for (int i = 2; i >= 0; i--) begin
      sendBit(3'b011 >> i);
      checkVal("t3histClr", {doneE, busyE}, 2'b00);
    end

    // 5: clkEn held low mid-forward
    payloadLen = 4'd5;
    sendBits(16'b1011, 4);
    checkVal("t5match", busyE, 1'b1);
    expQ.push_back(1'b1); expQ.push_back(1'b1); expQ.push_back(1'b0);
    expQ.push_back(1'b1); expQ.push_back(1'b0);
    sendBit(1'b1); sendBit(1'b1);
    checkVal("t5pre", {vldE, doneE, busyE}, 3'b101);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      clkEn = 1'b0;
      serIn = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      checkVal("t5hold", {serOutValidW, frameDoneW, busyW}, 3'b001);
      checkVal("t5holdCnt", countW, expW);
    end
    sendBit(1'b0); checkVal("t5p3", {vldE, doneE, busyE}, 3'b101);
    sendBit(1'b1); checkVal("t5p4", {vldE, doneE, busyE}, 3'b101);
    sendBit(1'b0); checkVal("t5p5", {vldE, doneE, busyE}, 3'b110);
    bumpCount("t5");

    // 6: async reset mid-forward
    payloadLen = 4'd6;
    sendBits(16'b1011, 4);
    expQ.push_back(1'b1); expQ.push_back(1'b1);
    sendBit(1'b1); sendBit(1'b1);
    checkVal("t6pre", {vldE, doneE, busyE}, 3'b101);
    #2;
    rst = 1'b1;
    #1;
    checkVal("t6rstOut", {serOutW, serOutValidW, frameDoneW, busyW, dbgW}, 5'b0);
    checkVal("t6rstCnt", {countW, countS}, 8'h00);
    expQ.delete();
    expW = 0;
    expS = 0;
    @(negedge clk);
    rst = 1'b0;
    payloadLen = 4'd1;
    for (int i = 2; i >= 0; i--) begin
      sendBit(3'b011 >> i);
      checkVal("t6partial", busyE, 1'b0);
    end
    sendBits(16'b101, 3);
    checkVal("t6preMatch", busyE, 1'b0);
    sendBit(1'b1);
    checkVal("t6match", busyE, 1'b1);
    expQ.push_back(1'b1);
    sendBit(1'b1);
    checkVal("t6end", {vldE, doneE, busyE}, 3'b110);
    bumpCount("t6");

    // 4: sixteen more empty frames take the total to 17
    payloadLen = 4'd0;
    for (int f = 0; f < 16; f++) begin
      sendBits(16'b1011, 4);
      checkVal("t4done", {doneE, busyE}, 2'b10);
      bumpCount("t4");
    end
    checkVal("t4wrap", countW, 4'd1);
    checkVal("t4sat", countS, 4'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_sequence_detector.md
# param_sequence_detector

Parametrised serial pattern detector and payload forwarder. It is the next generation of the lab-series sequence detector, with these additions:
- pattern width, pattern value and payload length are configurable;
- a wrap/saturate frame counter;
- a frame-done pulse.

It sits between a serial bit source and a downstream deserializer. It hunts for a start pattern on `serIn`, forwards the next N enabled bits on `serOut`/`serOutValid`, counts completed frames and returns to hunting.

## Interface
- `PAT_W`, 4: start-pattern width in bits (2..16).
- `LEN_W`, 4: width of the payload-length input; max payload is 2^LEN_W-1 bits.
- `CNT_W`, 4: width of the frame counter `countOut`.
- `SATURATE`, 0: 1 = `countOut` holds at all-ones; 0 = wraps to 0.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clkEn`  in  1  bit-strobe; all state advances only on `clk` edges with `clkEn`=1.
- `serIn`  in  1  serial data, sampled when `clkEn`=1.
- `pattern`  in  PAT_W  start pattern, MSB = first-received bit; compared live.
- `payloadLen`  in  LEN_W  payload length, captured at the match edge.
- `serOut`  out  1  forwarded payload bit (registered).
- `serOutValid`  out  1  one-`clk` pulse per forwarded bit.
- `countOut`  out  CNT_W  number of completed frames.
- `frameDone`  out  1  one-`clk` pulse after the last payload bit.
- `busy`  out  1  high while in FORWARD.

## Operation
States: HUNT and FORWARD. Reset enters HUNT.
- **HUNT:**
  - On each enabled edge, `serIn` shifts into a PAT_W history register (new bit at LSB).
  - A fill counter (0..PAT_W) increments and saturates at PAT_W.
  - A match occurs when the fill counter already equals PAT_W-1 or more before the edge, and the next history value {history[PAT_W-2:0], serIn} equals `pattern`.
- **Match with `payloadLen` ≠ 0:**
  - Load the remaining-bit counter with `payloadLen`.
  - Go to FORWARD.
- **Match with `payloadLen` = 0 (empty frame):**
  - Stay in HUNT.
  - Count the frame and pulse `frameDone` immediately.
  - Clear the history and fill counter.
- **FORWARD:**
  - On each enabled edge, `serOut` ← `serIn`, `serOutValid` ← 1, and the remaining counter decrements.
  - When the counter goes 1→0: return to HUNT, increment `countOut`, pulse `frameDone`.
  - The history and fill counter are cleared on entering HUNT, so patterns never overlap payload bits.
  - The pattern is not checked during FORWARD.
- **Overlap in HUNT:** the history is not cleared on a non-match, so overlapping patterns inside the hunt stream are found. Example: 1011011 matches 1011 once, then needs fresh bits after the frame.
- **`countOut` at the limit:** wraps all-ones→0 when SATURATE=0; holds all-ones when SATURATE=1.
- **Input changes:** changing `pattern` mid-hunt takes effect at the next enabled edge. Changing `payloadLen` during FORWARD has no effect.

## Timing
- **Reset values:** `serOut`=0, `serOutValid`=0, `countOut`=0, `frameDone`=0, `busy`=0. Also cleared: history, fill counter, remaining counter.
- **Reset mid-frame:** the frame is discarded and not counted.
- **Match latency:** the enabled edge that samples the last pattern bit makes `busy`=1 after that edge. The next enabled edge samples payload bit 1 and makes `serOutValid`=1 with `serOut` = that bit.
- **Per-bit pulses:**
  - `serOutValid` and `frameDone` are high for exactly one `clk` cycle after their enabled edge.
  - Both clear on the next `clk` edge, whether or not `clkEn` is high.
  - `serOut` holds its last value.
- **Frame end:**
  - `frameDone` and the `countOut` increment appear after the same edge as the last `serOutValid`.
  - `busy` drops after that same edge.
- **Hunt restart:** the bit on the enabled edge right after the last payload bit is the first hunt bit. A new match needs at least PAT_W enabled edges after the frame.
- **`clkEn` held low:** all state and outputs freeze, apart from the pulses clearing.
- **No bypass:** there is no combinational path from `serIn` to any output.

## Structure
- Shared package `seq_det_pkg` holds:
  - the state enum (HUNT, FORWARD);
  - the default parameter constants;
  - a function returning the saturating/wrapping counter increment.
- Natural sub-module: `pattern_shift_matcher`. It contains the history register, the fill counter and the match compare, with a clear input.
- The FSM, payload counter and output registers live in the top level.

## Test plan
All scenarios use PAT_W=4, `pattern`=4'b1011, LEN_W=4, CNT_W=4, with `clkEn` toggling every `clk` unless stated.
1. **Basic frame:** `payloadLen`=3, enabled bits 1,0,1,1,1,0,1 → `serOutValid` pulses 3 times with `serOut` 1,0,1; `frameDone` with the 3rd; `countOut`=1; `busy` high for exactly 3 enabled bits.
2. **Overlap / no-overlap:** stream 1,0,1,0,1,1 in HUNT → match on the 6th bit only. After a frame, payload bits 1,0,1,1 never trigger a match; the first post-frame match needs 4 fresh bits.
3. **Zero length:** `payloadLen`=0 → no `serOutValid`, `frameDone` pulse, `countOut`+1, `busy` stays 0.
4. **Counter wrap/saturate:** 17 frames → `countOut`=1 when SATURATE=0, and 15 when SATURATE=1.
5. **`clkEn` held low for 10 `clk` mid-FORWARD:** no state change and the remaining counter is unchanged. Pulses stay one `clk` wide. The frame completes after the remaining enabled bits.
6. **`rst` asserted asynchronously mid-FORWARD (between edges):** all outputs go to 0 immediately and `countOut` is not incremented. After release, a full pattern is required before the next frame.
